// File: rtl/upuart_tx_pkg.sv
// Shared bit positions and serializer state encoding for the UART transmit core.
// The PARITY state only exists when UPUART_TX_PARITY_EN is defined.
package upuart_tx_pkg;

  // CTRL register bits
  localparam int CTRL_TXEN   = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_PAREN  = 2;
  localparam int CTRL_PARODD = 3;

  // FIFO status register bits and count field
  localparam int FST_EMPTY   = 0;
  localparam int FST_FULL    = 1;
  localparam int FST_OVF     = 2;
  localparam int FST_BUSY    = 3;
  localparam int FST_CNT_LSB = 8;
  localparam int FST_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UPUART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_e;

endpackage

// File: rtl/upuart_tx_fifo.sv
// Byte-wide synchronous TX FIFO with flush; a push on full or a pop on empty is ignored.
// Flush takes priority over any same-cycle push or pop.
module upuart_tx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 1 << FIFO_AW;
  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   cnt_t;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == '0);
  assign full    = (count == cnt_t'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/upuart_tx.sv
// UART transmit core: CTRL/DIVD/FIFO registers, TX FIFO and 8N1 serializer.
// Define UPUART_TX_PARITY_EN to add the optional parity bit (CTRL PAREN/PARODD).
module upuart_tx
  import upuart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 3,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RST    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  ctrlr,
  input  logic                  divdr,
  input  logic                  datar,
  input  logic                  fifor,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  o_tx,
  output logic                  o_busy
);

  tx_state_e             state, state_nxt;
  logic                  txen;
  logic [DIV_WIDTH-1:0]  divd;
  logic [DIV_WIDTH-1:0]  div_lat;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  ovf;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [7:0]            fifo_head;
  logic [FIFO_AW:0]      fifo_count;
  logic                  flush;
  logic                  push;
  logic                  can_start;
  logic                  bit_done;
  logic                  load;
  logic                  unused_wdata;
`ifdef UPUART_TX_PARITY_EN
  logic                  paren;
  logic                  parodd;
  logic                  par_en_lat;
  logic                  par_bit;
`endif

  assign flush        = wr & ctrlr & wdata[CTRL_FLUSH];
  assign push         = wr & datar;
  assign can_start    = txen & ~fifo_empty;
  assign bit_done     = (baud_cnt == div_lat);
  // Pop the head byte on the cycle a frame starts, from IDLE or straight out of STOP.
  assign load         = can_start & ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
  assign unused_wdata = ^wdata[DATA_WIDTH-1:DIV_WIDTH];

  upuart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .flush (flush),
    .wdata (wdata[7:0]),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txen   <= 1'b0;
      divd   <= DIV_WIDTH'(DIV_RST);
`ifdef UPUART_TX_PARITY_EN
      paren  <= 1'b0;
      parodd <= 1'b0;
`endif
    end else begin
      if (wr & ctrlr) begin
        txen   <= wdata[CTRL_TXEN];
`ifdef UPUART_TX_PARITY_EN
        paren  <= wdata[CTRL_PAREN];
        parodd <= wdata[CTRL_PARODD];
`endif
      end
      if (wr & divdr) divd <= wdata[DIV_WIDTH-1:0];
    end
  end

  // A same-cycle overflow beats the read-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ovf <= 1'b0;
    else if (push & fifo_full & ~flush)   ovf <= 1'b1;
    else if (rd & fifor)                  ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (can_start) state_nxt = ST_START;
      ST_START:  if (bit_done)  state_nxt = ST_DATA;
      ST_DATA:   if (bit_done && bit_cnt == 3'd7) begin
`ifdef UPUART_TX_PARITY_EN
                   state_nxt = par_en_lat ? ST_PARITY : ST_STOP;
`else
                   state_nxt = ST_STOP;
`endif
                 end
`ifdef UPUART_TX_PARITY_EN
      ST_PARITY: if (bit_done)  state_nxt = ST_STOP;
`endif
      ST_STOP:   if (bit_done)  state_nxt = can_start ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      div_lat    <= '0;
`ifdef UPUART_TX_PARITY_EN
      par_en_lat <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else if (load) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= fifo_head;
      div_lat    <= divd;
`ifdef UPUART_TX_PARITY_EN
      par_en_lat <= paren;
      par_bit    <= (^fifo_head) ^ parodd;
`endif
    end else if (state != ST_IDLE) begin
      if (bit_done) begin
        baud_cnt <= '0;
        if (state == ST_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
      end
    end
  end

  // Decoded straight from the state so reset drives the line high asynchronously.
  always_comb begin
    o_tx   = 1'b1;
    o_busy = (state != ST_IDLE);
    case (state)
      ST_START:  o_tx = 1'b0;
      ST_DATA:   o_tx = shreg[0];
`ifdef UPUART_TX_PARITY_EN
      ST_PARITY: o_tx = par_bit;
`endif
      default:   o_tx = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (ctrlr) begin
        rdata[CTRL_TXEN]   = txen;
`ifdef UPUART_TX_PARITY_EN
        rdata[CTRL_PAREN]  = paren;
        rdata[CTRL_PARODD] = parodd;
`endif
      end
      if (divdr) rdata[DIV_WIDTH-1:0] = divd;
      if (fifor) begin
        rdata[FST_EMPTY]                   = fifo_empty;
        rdata[FST_FULL]                    = fifo_full;
        rdata[FST_OVF]                     = ovf;
        rdata[FST_BUSY]                    = o_busy;
        rdata[FST_CNT_LSB +: FST_CNT_W]    = FST_CNT_W'(fifo_count);
      end
    end
  end

endmodule
